// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a
// fixed gate of clk_in cycles and publishes each count with a strobe.
//   clk_in   : system clock, all logic on its rising edge
//   rst      : asynchronous active-low reset
//   enable   : measurement enable, synchronous to clk_in
//   sig_in   : signal under measurement, asynchronous to clk_in
//   freq_out : edges counted in the last completed window
//   valid    : one-cycle pulse when freq_out updates
//   overflow : count saturated in the last completed window
//   busy     : high while settling or measuring
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int          COUNT_WIDTH = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] freq_out,
  output logic                   valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [2:0] SETTLE_LAST = 3'(SYNC_STAGES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   del_q;
  logic                   edge_det;
  logic [2:0]             settle_q, settle_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] edge_q, edge_d;
  logic                   sat_q, sat_d;
  logic [COUNT_WIDTH-1:0] freq_q, freq_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH:0]   sum;
  logic [COUNT_WIDTH-1:0] cnt_sat;
  logic                   cnt_wrap;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~del_q;

  // One extra bit catches the add that would pass full scale.
  assign sum      = {1'b0, edge_q} + {{COUNT_WIDTH{1'b0}}, edge_det};
  assign cnt_wrap = sum[COUNT_WIDTH];
  assign cnt_sat  = cnt_wrap ? '1 : sum[COUNT_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    edge_d   = edge_q;
    sat_d    = sat_q;
    freq_d   = freq_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        settle_d = '0;
        gate_d   = '0;
        edge_d   = '0;
        sat_d    = 1'b0;
        if (enable) state_d = SETTLE;
      end
      SETTLE: begin
        // Edges seen here are synchronizer history, not signal.
        if (!enable) begin
          state_d  = IDLE;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = MEASURE;
          settle_d = '0;
          gate_d   = '0;
          edge_d   = '0;
          sat_d    = 1'b0;
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      MEASURE: begin
        if (gate_q == GATE_LAST) begin
          // Terminal-cycle edge closes with this window.
          freq_d  = cnt_sat;
          ovf_d   = sat_q | cnt_wrap;
          valid_d = 1'b1;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
          if (!enable) state_d = IDLE;
        end else if (!enable) begin
          state_d = IDLE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end else begin
          gate_d = gate_q + GW'(1);
          edge_d = cnt_sat;
          sat_d  = sat_q | cnt_wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      del_q    <= 1'b0;
      state_q  <= IDLE;
      settle_q <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
      freq_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      del_q    <= sync_q[SYNC_STAGES-1];
      state_q  <= state_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      edge_q   <= edge_d;
      sat_q    <= sat_d;
      freq_q   <= freq_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign freq_out = freq_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: random and directed stimulus for freq_meter,
// checked every cycle against a window-counting reference model.
module tb_freq_meter;

  localparam int G    = 40;
  localparam int CW   = 4;
  localparam int S    = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] freq_out;
  logic          valid;
  logic          overflow;
  logic          busy;

  int total = 0;
  int bad   = 0;

  freq_meter #(
    .GATE_CYCLES(G),
    .COUNT_WIDTH(CW),
    .SYNC_STAGES(S)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .enable  (enable),
    .sig_in  (sig_in),
    .freq_out(freq_out),
    .valid   (valid),
    .overflow(overflow),
    .busy    (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input longint got,
                     input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, got, want, $time);
    end
  endtask

  // Square-wave source: toggles every 'half' cycles, or holds.
  int   half = 0;
  logic hold_val = 1'b0;
  int   hc = 0;

  initial forever begin
    @(negedge clk_in);
    if (half == 0) begin
      sig_in = hold_val;
      hc = 0;
    end else if (hc >= half - 1) begin
      sig_in = ~sig_in;
      hc = 0;
    end else begin
      hc++;
    end
  end

  // Reference model: input samples per clock; a window's result is
  // the number of detected edges whose detection cycle lies inside
  // the window, clamped to full scale.
  bit samp [0:32767];
  int n = 0;
  int base = 0;
  int mode = 0;
  int settle_left = 0;
  int mstart = 0;
  logic [CW-1:0] e_freq = '0;
  logic          e_valid = 1'b0;
  logic          e_ovf = 1'b0;
  logic          e_busy = 1'b0;

  function automatic bit smp(input int k);
    if (k < base || k < 0) return 1'b0;
    return samp[k];
  endfunction

  // Edge detected in cycle t: rise seen S-1 and S samples back.
  function automatic int det(input int t);
    return (smp(t - S + 1) && !smp(t - S)) ? 1 : 0;
  endfunction

  always @(posedge clk_in or negedge rst) begin
    n = n + 1;
    if (!rst) begin
      base    = n + 1;
      mode    = 0;
      e_freq  = '0;
      e_valid = 1'b0;
      e_ovf   = 1'b0;
      e_busy  = 1'b0;
    end else begin
      samp[n] = sig_in;
      e_valid = 1'b0;
      case (mode)
        0: begin
          if (enable) begin
            mode = 1;
            settle_left = S;
          end
        end
        1: begin
          if (!enable) mode = 0;
          else if (settle_left == 0) begin
            mode = 2;
            mstart = n;
          end else settle_left--;
        end
        default: begin
          if (n - mstart >= G && (n - mstart) % G == 0) begin
            int c;
            c = 0;
            for (int t = n - G; t < n; t++) c += det(t);
            e_freq  = (c > MAXV) ? CW'(MAXV) : CW'(c);
            e_ovf   = (c > MAXV);
            e_valid = 1'b1;
            if (!enable) mode = 0;
          end else if (!enable) begin
            mode = 0;
          end
        end
      endcase
      e_busy = (mode != 0);
    end
  end

  always @(negedge clk_in) begin
    if (rst) begin
      chk("valid", valid, e_valid);
      chk("freq_out", freq_out, e_freq);
      chk("overflow", overflow, e_ovf);
      chk("busy", busy, e_busy);
    end
  end

  task automatic wait_valid(input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk_in);
      if (valid) seen = 1'b1;
    end
    chk("valid_seen", seen, 1);
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #($urandom_range(1, 4));
    rst = 1'b0;
    #1;
    chk("arst_freq", freq_out, 0);
    chk("arst_valid", valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    enable = 1'b1;
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_freq", freq_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);

    rst = 1'b1;
    half = 2;
    enable = 1'b1;
    wait_valid(200);
    wait_valid(200);
    chk("div4_freq", freq_out, 10);
    chk("div4_ovf", overflow, 0);

    half = 1;
    wait_valid(200);
    wait_valid(200);
    chk("div2_freq", freq_out, 15);
    chk("div2_ovf", overflow, 1);

    enable = 1'b0;
    hold_val = 1'b1;
    half = 0;
    repeat (10) @(negedge clk_in);
    enable = 1'b1;
    wait_valid(200);
    chk("held_freq", freq_out, 0);
    chk("held_ovf", overflow, 0);

    half = 2;
    wait_valid(200);
    wait_valid(200);
    chk("div4b_freq", freq_out, 10);
    repeat (20) @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("drop_busy", busy, 0);
    chk("drop_freq", freq_out, 10);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (i % 20 == 0) chk("drop_novalid", valid, 0);
    end
    enable = 1'b1;
    @(negedge clk_in);
    chk("reen_busy", busy, 1);
    wait_valid(200);
    chk("reen_freq", freq_out, 10);
    chk("reen_ovf", overflow, 0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) begin
        half = int'($urandom_range(0, 4));
        hold_val = 1'($urandom_range(0, 1));
      end
      if (i == 1990 || i == 3090) enable = 1'b1;
      if (i == 2000 || i == 3100) do_reset();
    end

    repeat (5) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
